// File: rtl/fp_hazard_ctrl.sv
// Hazard controller for a pipeline with a multi-cycle FP unit in EX.
// Merges load-use stalls, branch flushes and FP occupancy stalls into one set of pipeline controls.
module fp_hazard_ctrl #(
    parameter int LAT_W = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             FPOpE,
    input  logic [LAT_W-1:0] FPLatE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FPStart,
    output logic             FPBusy,
    output logic             FPResultValid,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [LAT_W-1:0] lat_eff;
    logic             lw_stall;

    assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
    assign lat_eff  = (FPLatE == '0) ? LAT_W'(1) : FPLatE;

    // FP handshake: FPStart is a single-cycle pulse issued only from IDLE when the op
    // enters EX; FPResultValid is asserted for exactly one cycle, the op's last in EX.
    // Neither waits on a ready: the FP unit is assumed always able to accept and deliver.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushM        = 1'b0;
        FPStart       = 1'b0;
        FPBusy        = 1'b0;
        FPResultValid = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (FPOpE) begin
                        // FP takes priority over load-use; a load cannot also be an FP op
                        FPStart = 1'b1;
                        if (lat_eff == LAT_W'(1)) begin
                            FPResultValid = 1'b1;
                        end else begin
                            StallF  = 1'b1;
                            StallD  = 1'b1;
                            StallE  = 1'b1;
                            FlushM  = 1'b1;
                            cnt_d   = lat_eff - LAT_W'(2);
                            state_d = RUN;
                        end
                    end else begin
                        if (lw_stall) begin
                            StallF = 1'b1;
                            StallD = 1'b1;
                            FlushE = 1'b1;
                        end
                        if (PCSrcE) begin
                            FlushD = 1'b1;
                            FlushE = 1'b1;
                        end
                    end
                end
                RUN: begin
                    FPBusy = 1'b1;
                    if (cnt_q != '0) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                        cnt_d  = cnt_q - LAT_W'(1);
                    end else begin
                        FPResultValid = 1'b1;
                        state_d       = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (StallF && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign StallCount = reset ? '0 : stall_cnt_q;

endmodule
